uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single UART transmitter of the SoC between `NUM_REQ` byte-stream requesters, for example CPU console output and a debug/boot monitor. It grants the transmitter for a whole message, meaning bytes up to and including one flagged `last`, so lines from different sources never interleave. It uses round-robin fairness and a stall watchdog that reclaims the transmitter from a requester that stops mid-message. It sits between the requesters and the UART TX serializer inside `simple_soc`, in the 25 MHz system clock domain.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, at least 2.
- `TIMEOUT_CYCLES`, default 2_500_000: consecutive stalled cycles while locked before forced release. 0 disables the watchdog.
- `IDW`: derived as `$clog2(NUM_REQ)`, minimum 1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester byte valid.
- `req_data`  in  NUM_REQ*8  packed bytes; requester i uses bits [8i+7:8i].
- `req_last`  in  NUM_REQ  marks the final byte of a message.
- `req_ready`  out  NUM_REQ  per-requester byte accepted.
- `tx_valid`  out  1  byte valid to the UART serializer.
- `tx_data`  out  8  byte to the UART serializer.
- `tx_ready`  in  1  serializer can accept a byte.
- `grant_valid`  out  1  the arbiter is in LOCKED.
- `grant_id`  out  IDW  index of the current owner.
- `timeout`  out  1  one-cycle pulse when the watchdog forces a release.

## Operation
- A handshake on any side occurs when valid and ready are both high on a rising edge.
- **States: IDLE, LOCKED.**
- **IDLE:**
  - All `req_ready` = 0, `tx_valid` = 0, `grant_valid` = 0.
  - If any `req_valid` is high, choose the first asserted index scanning upward from `rr_ptr` and wrapping modulo `NUM_REQ`.
  - Register it into `grant_id` and go to LOCKED.
- **LOCKED:** combinational pass-through for owner g only.
  - `tx_valid` = `req_valid[g]`, `tx_data` = `req_data[g]`.
  - `req_ready[g]` = `tx_ready`; every other `req_ready` = 0.
- **Normal release:** a handshake with `req_last[g]` = 1 sets `rr_ptr` = (g+1) mod `NUM_REQ` and goes to IDLE.
- **Watchdog:**
  - `stall_cnt` clears on entry to LOCKED and on every handshake.
  - It increments on each LOCKED cycle without a handshake.
  - When it reaches `TIMEOUT_CYCLES`, do three things in that cycle: pulse `timeout`, set `rr_ptr` = (g+1) mod `NUM_REQ`, go to IDLE.
  - If a handshake with `last` and the watchdog expiry coincide, the handshake wins: normal release, no `timeout` pulse.
- **Stall semantics:** a requester holding `req_valid` high while `tx_ready` is low is stalled. This is counted by the watchdog, because a hung serializer must not lock the bus forever.
- **Wrap-around:** `rr_ptr` wraps from `NUM_REQ`-1 to 0. For a non-power-of-2 `NUM_REQ`, the modulo is an explicit compare, not a bit truncation.
- **Counter width:** `stall_cnt` is `$clog2(TIMEOUT_CYCLES+1)` bits and saturates, never wraps.
- **Reset mid-message:** state becomes IDLE and all outputs drop in the same cycle. No partial-byte side effects, because the serializer owns byte framing.

## Timing
- **Reset values:** state IDLE, `rr_ptr` 0, `grant_id` 0, `stall_cnt` 0, `timeout` 0. All combinational outputs are therefore 0.
- **Arbitration latency:** `req_valid` seen in IDLE at cycle n gives `grant_valid` = 1 and `tx_valid` = 1 at cycle n+1. The first byte can be accepted at edge n+1.
- **Throughput while locked:** one byte per cycle, limited only by `tx_ready`.
- **Release bubble:** exactly one IDLE cycle after any release before the next grant.
- **Combinational paths:** `tx_ready` to `req_ready` and `req_*` to `tx_*` are combinational. Registered outputs are `grant_valid`, `grant_id` and `timeout`.

## Test plan
- **Single requester:** req 0 sends 0x48, 0x69, 0x0A (`last` on 0x0A) with `tx_ready` = 1. Required: `grant_valid` rises 1 cycle after `req_valid`, `tx_data` shows 0x48/0x69/0x0A on consecutive cycles, then IDLE with `rr_ptr` = 1.
- **Simultaneous requests:** req 0 and req 1 raise `req_valid` in the same cycle after reset. Required: req 0 is granted first. After its `last`, exactly one bubble cycle follows, then req 1 is granted. The two messages never interleave, confirmed by checking the `tx_data` sequence.
- **Fairness with `NUM_REQ` = 3:** all three requesters continuously send 1-byte messages. Required: grants rotate 0, 1, 2, 0, 1, 2 and wrap correctly from 2 to 0.
- **Watchdog with `TIMEOUT_CYCLES` = 8:** req 1 is granted, sends one non-last byte, then drops `req_valid`. Required: `timeout` pulses exactly 8 cycles after that handshake, the arbiter returns to IDLE, and waiting req 0 is granted 1 cycle later.
- **Backpressure:** `tx_ready` = 0 for 5 cycles mid-message with `TIMEOUT_CYCLES` = 8. Required: byte held stable, `req_ready` = 0, no timeout, transfer completes when `tx_ready` returns.
- **Reset mid-message:** assert `reset` for 1 cycle during req 0's second byte. Required: all outputs are 0 on the next cycle and the next grant starts from index 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular round-robin arbiter for the shared UART transmitter
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 2_500_000,
    localparam int IDW           = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic                 grant_valid,
    output logic [IDW-1:0]       grant_id,
    output logic                 timeout
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr, rr_nxt, grant_nxt, pick;
    logic [CW-1:0]  stall_cnt, stall_nxt, stall_inc;
    logic           timeout_nxt, found, handshake, expire;
    int             scan_idx;

    // Explicit compare keeps the wrap correct for non-power-of-2 NUM_REQ.
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
        return (int'(v) == NUM_REQ - 1) ? '0 : v + IDW'(1);
    endfunction

    always_comb begin
        pick     = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
            if (!found && req_valid[scan_idx]) begin
                found = 1'b1;
                pick  = IDW'(scan_idx);
            end
        end
    end

    assign handshake = (state == LOCKED) && req_valid[grant_id] && tx_ready;
    assign stall_inc = (stall_cnt == '1) ? stall_cnt : stall_cnt + CW'(1);
    assign expire    = (TIMEOUT_CYCLES != 0) && (stall_inc == CW'(TIMEOUT_CYCLES));

    always_comb begin
        state_nxt   = state;
        rr_nxt      = rr_ptr;
        grant_nxt   = grant_id;
        stall_nxt   = stall_cnt;
        timeout_nxt = 1'b0;
        req_ready   = '0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = LOCKED;
                    grant_nxt = pick;
                    stall_nxt = '0;
                end
            end
            LOCKED: begin
                tx_valid            = req_valid[grant_id];
                tx_data             = req_data[{grant_id, 3'b000} +: 8];
                req_ready[grant_id] = tx_ready;
                if (handshake) begin
                    stall_nxt = '0;
                    if (req_last[grant_id]) begin
                        state_nxt = IDLE;
                        rr_nxt    = wrap_inc(grant_id);
                    end
                end else begin
                    // A stalled serializer counts too, so a hung TX cannot hold the bus.
                    stall_nxt = stall_inc;
                    if (expire) begin
                        timeout_nxt = 1'b1;
                        state_nxt   = IDLE;
                        rr_nxt      = wrap_inc(grant_id);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            grant_id  <= grant_nxt;
            stall_cnt <= stall_nxt;
            timeout   <= timeout_nxt;
        end
    end

    assign grant_valid = (state == LOCKED);

endmodule
